cmp_arbiter: RTL

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter_pkg.sv | 12 +
 rtl/cmp_arbiter_cmp.sv | 16 +
 rtl/cmp_arbiter.sv | 96 +++++++++
 3 files changed

// File: rtl/cmp_arbiter_pkg.sv
// Shared definitions for the two-requester compare arbiter.
package cmp_arbiter_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_arbiter_cmp.sv
// Unsigned magnitude comparator shared by both requesters.
module cmp_arbiter_cmp #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             greater,
  output logic             equal,
  output logic             lesser
);

  assign greater = (A > B);
  assign equal   = (A == B);
  assign lesser  = (A < B);

endmodule

// File: rtl/cmp_arbiter.sv
// Round-robin arbiter granting two requesters access to one comparator,
// with a held response stage under consumer backpressure.
module cmp_arbiter
  import cmp_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic             rsp_gt,
  output logic             rsp_eq,
  output logic             rsp_lt
);

  state_t           state;
  logic             last;
  logic             sel;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             greater;
  logic             equal;
  logic             lesser;

  cmp_arbiter_cmp #(.WIDTH(WIDTH)) u_cmp (
    .A       (opa),
    .B       (opb),
    .greater (greater),
    .equal   (equal),
    .lesser  (lesser)
  );

  // On contention, the requester not granted last wins; last resets to 1 so 0 wins first.
  always_comb begin
    sel = 1'b0;
    gnt = '0;
    if (req == 2'b10)
      sel = 1'b1;
    else if (req == 2'b11)
      sel = ~last;
    if (rst_n && (state == IDLE) && (req != 2'b00))
      gnt = sel ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last      <= 1'b1;
      opa       <= '0;
      opb       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_gt    <= 1'b0;
      rsp_eq    <= 1'b0;
      rsp_lt    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req != 2'b00) begin
            opa   <= sel ? a1 : a0;
            opb   <= sel ? b1 : b0;
            last  <= sel;
            state <= CMP;
          end
        end
        CMP: begin
          rsp_gt    <= greater;
          rsp_eq    <= equal;
          rsp_lt    <= lesser;
          rsp_id    <= last;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_gt    <= 1'b0;
            rsp_eq    <= 1'b0;
            rsp_lt    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
